// File: rtl/instruction_fetcher.sv
// instruction_fetcher: req/ack instruction fetch stage started and stopped by the controller's fetcher_reset level.
// Define INSTRUCTION_FETCHER_ICACHE_EN to build the direct-mapped instruction cache and its LOOKUP state.
module instruction_fetcher #(
    parameter int CACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetcher_reset,
    input  logic [31:0] pc,
    output logic        fetcher_completed,
    output logic [31:0] instruction,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        icache_flush
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] REQ    = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [29:0] addr_q, addr_d;
    logic        hit;
    logic [31:0] hit_data;
    logic        fill;
    logic [1:0]  start_state;

    assign fill = (state_q == REQ) && mem_ack;

`ifdef INSTRUCTION_FETCHER_ICACHE_EN
    localparam int IDX_W = $clog2(CACHE_LINES);

    logic [CACHE_LINES-1:0] valid_q;
    logic [29-IDX_W:0]      tag_q  [CACHE_LINES];
    logic [31:0]            data_q [CACHE_LINES];
    logic [IDX_W-1:0]       idx;
    logic                   unused_pc;

    assign idx         = addr_q[IDX_W-1:0];
    assign hit         = valid_q[idx] && (tag_q[idx] == addr_q[29:IDX_W]) && !icache_flush;
    assign hit_data    = data_q[idx];
    assign start_state = LOOKUP;
    assign unused_pc   = ^pc[1:0];

    // A flush in the same cycle as a fill leaves the line invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) valid_q <= '0;
        else if (icache_flush) valid_q <= '0;
        else if (fill) valid_q[idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[idx]  <= addr_q[29:IDX_W];
            data_q[idx] <= mem_rdata;
        end
    end
`else
    logic unused_bits;

    assign hit         = 1'b0;
    assign hit_data    = '0;
    assign start_state = REQ;
    assign unused_bits = ^{pc[1:0], icache_flush, fill};
`endif

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                state_d = fetcher_reset ? IDLE : start_state;
                addr_d  = fetcher_reset ? addr_q : pc[31:2];
            end
            LOOKUP: begin
                state_d = fetcher_reset ? IDLE : (hit ? DONE : REQ);
                instr_d = (!fetcher_reset && hit) ? hit_data : instr_q;
            end
            // A memory transaction always runs to its ack, even when aborted.
            REQ: begin
                state_d = !mem_ack ? REQ : (fetcher_reset ? IDLE : DONE);
                instr_d = mem_ack ? mem_rdata : instr_q;
            end
            default: state_d = fetcher_reset ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            instr_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
        end
    end

    assign fetcher_completed = (state_q == DONE);
    assign mem_req           = (state_q == REQ);
    assign mem_addr          = addr_q;
    assign instruction       = instr_q;
endmodule
